agg_scheduler: RTL

AGG_SCHEDULER -- requirements
Module: agg_scheduler

---
 rtl/agg_sched_pkg.sv | 17 +
 rtl/agg_sched_select.sv | 77 +++++++
 rtl/agg_scheduler.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/agg_sched_pkg.sv
// agg_sched_pkg
// Shared definitions for the aggregating priority scheduler:
//   - default parameter constants used by agg_scheduler and agg_sched_select
//   - the grant FSM state type (IDLE = no offer, OFFER = grant register valid)
package agg_sched_pkg;

    localparam int unsigned DEF_REQ_CNT    = 5;
    localparam int unsigned DEF_KEY_WIDTH  = 6;
    localparam int unsigned DEF_DATA_WIDTH = 16;
    localparam int unsigned DEF_AGE_WIDTH  = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } sched_state_e;

endpackage

// File: rtl/agg_sched_select.sv
// agg_sched_select
// Combinational winner selection for agg_scheduler, built as a binary min-tree.
// Ports:
//   vld     in  REQ_CNT            slot valid (eligible) bits
//   key     in  REQ_CNT*KEY_WIDTH  slot keys, slot i at [i*KEY_WIDTH +: KEY_WIDTH]
//   sat     in  REQ_CNT            slot age saturated (beats every unsaturated slot)
//   any_vld out 1                  at least one slot is eligible
//   sel_idx out $clog2(REQ_CNT)    index of the winning slot
//   sel_key out KEY_WIDTH          key of the winning slot
// Ordering: saturated before unsaturated, then smaller key, then lower index.
module agg_sched_select
    import agg_sched_pkg::*;
#(
    parameter int unsigned REQ_CNT   = DEF_REQ_CNT,
    parameter int unsigned KEY_WIDTH = DEF_KEY_WIDTH,
    localparam int unsigned IDX_W    = $clog2(REQ_CNT)
) (
    input  logic [REQ_CNT-1:0]           vld,
    input  logic [REQ_CNT*KEY_WIDTH-1:0] key,
    input  logic [REQ_CNT-1:0]           sat,
    output logic                         any_vld,
    output logic [IDX_W-1:0]             sel_idx,
    output logic [KEY_WIDTH-1:0]         sel_key
);

    // Leaves padded up to a power of two; padding leaves are never valid.
    localparam int unsigned LEAVES = 1 << IDX_W;

    // Heap-style numbering: node n has children 2n and 2n+1, root is node 1,
    // leaf i sits at LEAVES+i. Node 0 is unused.
    logic                 node_vld [2*LEAVES];
    logic                 node_sat [2*LEAVES];
    logic [KEY_WIDTH-1:0] node_key [2*LEAVES];
    logic [IDX_W-1:0]     node_idx [2*LEAVES];
    logic                 take_r;

    // The left child always covers lower indices than the right one, so the
    // right child only wins when it is strictly better; that yields the
    // lowest-index tie break without comparing indices.
    always_comb begin
        take_r = 1'b0;
        for (int n = 0; n < 2 * LEAVES; n++) begin
            node_vld[n] = 1'b0;
            node_sat[n] = 1'b0;
            node_key[n] = '0;
            node_idx[n] = '0;
        end
        for (int i = 0; i < REQ_CNT; i++) begin
            node_vld[LEAVES+i] = vld[i];
            node_sat[LEAVES+i] = sat[i];
            node_key[LEAVES+i] = key[i*KEY_WIDTH +: KEY_WIDTH];
            node_idx[LEAVES+i] = IDX_W'(i);
        end
        for (int n = LEAVES - 1; n >= 1; n--) begin
            take_r = node_vld[2*n+1] &&
                     (!node_vld[2*n] ||
                      (node_sat[2*n+1] && !node_sat[2*n]) ||
                      ((node_sat[2*n+1] == node_sat[2*n]) &&
                       (node_key[2*n+1] < node_key[2*n])));
            if (take_r) begin
                node_vld[n] = node_vld[2*n+1];
                node_sat[n] = node_sat[2*n+1];
                node_key[n] = node_key[2*n+1];
                node_idx[n] = node_idx[2*n+1];
            end else begin
                node_vld[n] = node_vld[2*n];
                node_sat[n] = node_sat[2*n];
                node_key[n] = node_key[2*n];
                node_idx[n] = node_idx[2*n];
            end
        end
        any_vld = node_vld[1];
        sel_idx = node_idx[1];
        sel_key = node_key[1];
    end

endmodule

// File: rtl/agg_scheduler.sv
// agg_scheduler
// Per-requester slot store feeding a single grant register. Each cycle the
// valid slot with the smallest key is moved into the grant register whenever
// the register is empty or being accepted.
// Ports:
//   clk        in   1                   rising-edge clock
//   rst        in   1                   asynchronous active-high reset
//   flush      in   1                   synchronous clear of slots and grant register
//   req_vld    in   REQ_CNT             per-requester request valid
//   req_key    in   REQ_CNT*KEY_WIDTH   per-requester key (smaller = higher priority)
//   req_data   in   REQ_CNT*DATA_WIDTH  per-requester payload
//   req_rdy    out  REQ_CNT             slot i is free
//   gnt_vld    out  1                   grant offer valid
//   gnt_rdy    in   1                   consumer accepts the offer
//   gnt_id     out  $clog2(REQ_CNT)     winning requester index
//   gnt_key    out  KEY_WIDTH           winner's key
//   gnt_data   out  DATA_WIDTH          winner's payload
//   occupancy  out  $clog2(REQ_CNT+1)   valid slots, not counting the grant register
// Build option: define SCHED_AGING_EN to add per-slot age counters; a slot whose
// counter saturates beats every unsaturated slot.
module agg_scheduler
    import agg_sched_pkg::*;
#(
    parameter int unsigned REQ_CNT    = DEF_REQ_CNT,
    parameter int unsigned KEY_WIDTH  = DEF_KEY_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned AGE_WIDTH  = DEF_AGE_WIDTH,
    localparam int unsigned IDX_W     = $clog2(REQ_CNT),
    localparam int unsigned OCC_W     = $clog2(REQ_CNT + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic [REQ_CNT-1:0]            req_vld,
    input  logic [REQ_CNT*KEY_WIDTH-1:0]  req_key,
    input  logic [REQ_CNT*DATA_WIDTH-1:0] req_data,
    output logic [REQ_CNT-1:0]            req_rdy,
    output logic                          gnt_vld,
    input  logic                          gnt_rdy,
    output logic [IDX_W-1:0]              gnt_id,
    output logic [KEY_WIDTH-1:0]          gnt_key,
    output logic [DATA_WIDTH-1:0]         gnt_data,
    output logic [OCC_W-1:0]              occupancy
);

    sched_state_e            state_q, state_d;
    logic [REQ_CNT-1:0]      slot_vld_q, slot_vld_d;
    logic [KEY_WIDTH-1:0]    slot_key_q  [REQ_CNT];
    logic [KEY_WIDTH-1:0]    slot_key_d  [REQ_CNT];
    logic [DATA_WIDTH-1:0]   slot_data_q [REQ_CNT];
    logic [DATA_WIDTH-1:0]   slot_data_d [REQ_CNT];
    logic [IDX_W-1:0]        gnt_id_q, gnt_id_d;
    logic [KEY_WIDTH-1:0]    gnt_key_q, gnt_key_d;
    logic [DATA_WIDTH-1:0]   gnt_data_q, gnt_data_d;
    logic [OCC_W-1:0]        occ_q, occ_d;

    logic [REQ_CNT-1:0]           cap;
    logic [REQ_CNT-1:0]           load_hit;
    logic [REQ_CNT-1:0]           slot_sat;
    logic [REQ_CNT*KEY_WIDTH-1:0] slot_key_flat;
    logic                         any_vld;
    logic                         load;
    logic [IDX_W-1:0]             sel_idx;
    logic [KEY_WIDTH-1:0]         sel_key;
    logic [DATA_WIDTH-1:0]        sel_data;
    logic [OCC_W-1:0]             cap_cnt;

    assign req_rdy   = ~slot_vld_q & {REQ_CNT{~flush}};
    assign cap       = req_vld & req_rdy;
    assign gnt_vld   = (state_q == OFFER);
    assign gnt_id    = gnt_id_q;
    assign gnt_key   = gnt_key_q;
    assign gnt_data  = gnt_data_q;
    assign occupancy = occ_q;

    // Only registered slots are offered to the tree, so a request captured on
    // the same edge as a load cannot take part in it.
    always_comb begin
        slot_key_flat = '0;
        for (int i = 0; i < REQ_CNT; i++) begin
            slot_key_flat[i*KEY_WIDTH +: KEY_WIDTH] = slot_key_q[i];
        end
    end

    agg_sched_select #(
        .REQ_CNT   (REQ_CNT),
        .KEY_WIDTH (KEY_WIDTH)
    ) u_select (
        .vld     (slot_vld_q),
        .key     (slot_key_flat),
        .sat     (slot_sat),
        .any_vld (any_vld),
        .sel_idx (sel_idx),
        .sel_key (sel_key)
    );

    assign load = any_vld && ((state_q == IDLE) || gnt_rdy) && !flush;

    always_comb begin
        sel_data = '0;
        load_hit = '0;
        cap_cnt  = '0;
        for (int i = 0; i < REQ_CNT; i++) begin
            if (sel_idx == IDX_W'(i)) begin
                sel_data    = slot_data_q[i];
                load_hit[i] = load;
            end
            cap_cnt = cap_cnt + OCC_W'(cap[i]);
        end
    end

`ifdef SCHED_AGING_EN
    logic [AGE_WIDTH-1:0] age_q [REQ_CNT];
    logic [AGE_WIDTH-1:0] age_d [REQ_CNT];

    // Age restarts whenever the slot is (re)filled, emptied or flushed, and
    // otherwise counts waiting cycles up to all-ones.
    always_comb begin
        for (int i = 0; i < REQ_CNT; i++) begin
            age_d[i]    = age_q[i];
            slot_sat[i] = slot_vld_q[i] && (&age_q[i]);
            if (flush || cap[i] || load_hit[i] || !slot_vld_q[i]) begin
                age_d[i] = '0;
            end else if (!(&age_q[i])) begin
                age_d[i] = age_q[i] + AGE_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REQ_CNT; i++) begin
                age_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < REQ_CNT; i++) begin
                age_q[i] <= age_d[i];
            end
        end
    end
`else
    // No age counters: nothing is ever preferred over plain min-key order.
    // A zero-width age could not count, so that case also degenerates to
    // every slot sharing one group.
    assign slot_sat = {REQ_CNT{AGE_WIDTH == 0}};
`endif

    // Slot store: capture and load can never hit the same slot (capture needs
    // the slot empty, load needs it full), so their order here is irrelevant.
    always_comb begin
        slot_vld_d = slot_vld_q;
        for (int i = 0; i < REQ_CNT; i++) begin
            slot_key_d[i]  = slot_key_q[i];
            slot_data_d[i] = slot_data_q[i];
            if (flush) begin
                slot_vld_d[i] = 1'b0;
            end else if (cap[i]) begin
                slot_vld_d[i]  = 1'b1;
                slot_key_d[i]  = req_key[i*KEY_WIDTH +: KEY_WIDTH];
                slot_data_d[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end else if (load_hit[i]) begin
                slot_vld_d[i] = 1'b0;
            end
        end
    end

    // Grant register and FSM. The register only changes on a load or flush,
    // which keeps the offer stable while it is being back-pressured.
    always_comb begin
        state_d    = state_q;
        gnt_id_d   = gnt_id_q;
        gnt_key_d  = gnt_key_q;
        gnt_data_d = gnt_data_q;
        occ_d      = occ_q + cap_cnt - OCC_W'(load);
        if (load) begin
            gnt_id_d   = sel_idx;
            gnt_key_d  = sel_key;
            gnt_data_d = sel_data;
        end
        case (state_q)
            IDLE: begin
                if (load) begin
                    state_d = OFFER;
                end
            end
            OFFER: begin
                if (gnt_rdy && !load) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d    = IDLE;
            gnt_id_d   = '0;
            gnt_key_d  = '0;
            gnt_data_d = '0;
            occ_d      = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            slot_vld_q <= '0;
            gnt_id_q   <= '0;
            gnt_key_q  <= '0;
            gnt_data_q <= '0;
            occ_q      <= '0;
            for (int i = 0; i < REQ_CNT; i++) begin
                slot_key_q[i]  <= '0;
                slot_data_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            slot_vld_q <= slot_vld_d;
            gnt_id_q   <= gnt_id_d;
            gnt_key_q  <= gnt_key_d;
            gnt_data_q <= gnt_data_d;
            occ_q      <= occ_d;
            for (int i = 0; i < REQ_CNT; i++) begin
                slot_key_q[i]  <= slot_key_d[i];
                slot_data_q[i] <= slot_data_d[i];
            end
        end
    end

endmodule
